rv_dmem_rsp: RTL
================

Name: rv_dmem_rsp

Overview:
Data-memory responder: the far end of the core's t_core2mem_req data port issued from the memory-access stage (Q103H).
- Accepts one load/store per handshake and applies byte-enabled writes to an internal word array.
- Returns load data with a fixed, configurable access latency.
- Back-pressures the core via a ready signal, which the core uses to stall Q103H.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the array (power of 2).
ACCESS_LATENCY, 1, cycles from request acceptance to response (L >= 1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset (0 = reset asserted).
core2dmem_req_Q103H  input  t_core2mem_req  request fields: wr_data[31:0], address[31:0], wr_en, rd_en, byte_en[3:0].
dmem_ready_Q103H  output  1  responder can accept a request this cycle.
rsp_rd_data  output  32  load data; meaningful only while rsp_rd_valid = 1.
rsp_rd_valid  output  1  one-cycle pulse per completed load.
rsp_err  output  1  one-cycle pulse per errored request.

Behaviour:
- Reset (rst = 0, async): state IDLE, counter 0, dmem_ready = 1, rsp_rd_valid = 0, rsp_rd_data = 0, rsp_err = 0.
  - Any pending request is dropped.
  - Array contents are not reset.
- Accept: a request is accepted at a rising edge when (rd_en | wr_en) & dmem_ready. The whole request is captured.
- Word index = address[log2(MEM_WORDS)+1:2]. address[1:0] is ignored; the core pre-aligns data to byte_en lanes.
- Out of range: any 1 in address[31:log2(MEM_WORDS)+2].
  - Write is dropped.
  - Read returns 0 with rsp_rd_valid = 1.
  - rsp_err pulses with the response.
- rd_en & wr_en both set: treated as a write only. No read response is produced; rsp_err pulses.
- Write: only lanes with byte_en[i] = 1 update bits [8i+7:8i]. byte_en = 0 with wr_en is a legal no-op.
- Read: returns the full 32-bit word regardless of byte_en.
- State machine:
  - IDLE: dmem_ready = 1. On accept, if L = 1, perform the access at the same edge. Otherwise go to BUSY with cnt = L-2.
  - BUSY: dmem_ready = 0. Each cycle, cnt decrements. When cnt = 0, perform the access at that edge and return to IDLE.
- Timing:
  - Access at an edge makes rsp_* visible in the following cycle. Request accepted at edge T gives the response in cycle T+L.
  - Writes produce no rsp_rd_valid.
- Throughput:
  - L = 1: fully pipelined, one request per cycle, dmem_ready never drops. Response lines up with Q104H.
  - L > 1: dmem_ready is low for L-1 cycles after each accept. It returns high in the response cycle, so a new request can be accepted in that cycle.
- Ordering: a write commits at its access edge. Any later read accepted after it returns the new data, including a back-to-back read at L = 1.
- Reset mid-BUSY: the request is abandoned, the write is not committed, and no response is produced.
- rsp_rd_data holds its last value when rsp_rd_valid = 0.

Decomposition:
- rv_pkg:
  - existing t_core2mem_req
  - new t_dmem_rsp {rd_data, rd_valid, err}
  - DMEM_ACCESS_LATENCY default constant
  - t_dmem_state enum {DMEM_IDLE, DMEM_BUSY}
- Sub-module rv_dmem_array: MEM_WORDS x 32 storage.
  - Synchronous byte-lane write and synchronous read.
  - Single port: read or write per cycle.
  - Instantiated once.
- Register and flip-flop coding uses dff_macros.svh.

Test Plan:
1. Reset: drive rst = 0 mid-stream -> all rsp_* = 0 and dmem_ready = 1 immediately, asynchronously.
2. L = 1, full-word store then load:
   - Write 0xDEADBEEF to 0x10 (byte_en = 4'hF) at T, read 0x10 at T+1.
   - rsp_rd_valid = 1 with 0xDEADBEEF in cycle T+2; dmem_ready stays 1 throughout.
3. Partial store to the word from scenario 2:
   - Write 0x0000AA00 with byte_en = 4'b0010 to 0x10, then read 0x10.
   - Read returns 0xDEADAAEF.
4. L = 3, load accepted at T:
   - dmem_ready = 0 in cycles T+1 and T+2.
   - rsp_rd_valid pulses in cycle T+3; dmem_ready = 1 in T+3, and a request held there is accepted.
5. Out-of-range and illegal requests with MEM_WORDS = 1024:
   - Read 0x00001000 -> rd_data = 0, rsp_rd_valid = 1, rsp_err = 1.
   - Write 0x00001000 -> rsp_err = 1, no array change.
   - rd_en = wr_en = 1 -> write performed, rsp_err = 1, no rsp_rd_valid.
6. L = 3, write 0x12345678 to 0x20, rst pulse in cycle T+1 -> no response; a later read of 0x20 returns the prior contents.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the core-to-memory data path.
//   t_core2mem_req : request issued by the memory-access stage (Q103H)
//   t_dmem_rsp     : response returned by the data-memory responder
//   t_dmem_state   : responder sequencing states
package rv_pkg;

    typedef struct packed {
        logic [31:0] wr_data;
        logic [31:0] address;
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  byte_en;
    } t_core2mem_req;

    typedef struct packed {
        logic [31:0] rd_data;
        logic        rd_valid;
        logic        err;
    } t_dmem_rsp;

    localparam int DMEM_ACCESS_LATENCY = 1;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_BUSY = 1'b1
    } t_dmem_state;

endpackage

// File: rtl/rv_dmem_array.sv
// Single-port MEM_WORDS x 32 storage with byte-lane writes and a registered read.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset (read register only, contents untouched)
//   we       : write strobe, lanes selected by byte_en
//   re       : read strobe, loads rd_data with the addressed word
//   addr     : word index
//   wr_data  : write data, already aligned to byte lanes
//   byte_en  : per-lane write enable
//   rd_data  : registered read data, holds between reads
module rv_dmem_array #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    byte_en,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/rv_dmem_rsp.sv
// Data-memory responder at the far end of the core's Q103H data port.
// Accepts one load/store per handshake, returns load data ACCESS_LATENCY cycles
// after acceptance, and holds dmem_ready low while a multi-cycle access is pending.
// Ports:
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   core2dmem_req_Q103H : request (wr_data, address, wr_en, rd_en, byte_en)
//   dmem_ready_Q103H    : request can be accepted this cycle
//   rsp_rd_data         : load data, holds its last value when not valid
//   rsp_rd_valid        : one-cycle pulse per completed load
//   rsp_err             : one-cycle pulse per out-of-range or rd+wr request
//
// state     | meaning
// DMEM_IDLE | ready; with latency 1 the access happens at the accepting edge
// DMEM_BUSY | request held in req_q; access at the edge where cnt_q reaches 0
module rv_dmem_rsp
    import rv_pkg::*;
#(
    parameter int MEM_WORDS      = 1024,
    parameter int ACCESS_LATENCY = DMEM_ACCESS_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    input  t_core2mem_req core2dmem_req_Q103H,
    output logic          dmem_ready_Q103H,
    output logic [31:0]   rsp_rd_data,
    output logic          rsp_rd_valid,
    output logic          rsp_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(ACCESS_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_LATENCY > 1 ? ACCESS_LATENCY - 2 : 0);

    t_dmem_state   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    t_core2mem_req req_q, req_d;

    logic          accept;
    logic          acc_fire;
    t_core2mem_req acc_req;
    logic          acc_oor;
    logic          acc_rd;
    logic          arr_we;
    logic          arr_re;
    logic [31:0]   arr_rd_data;

    logic          rd_valid_q;
    logic          err_q;
    logic          zero_q;
    t_dmem_rsp     rsp;

    assign accept = (core2dmem_req_Q103H.rd_en | core2dmem_req_Q103H.wr_en) & dmem_ready_Q103H;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        req_d            = req_q;
        dmem_ready_Q103H = 1'b1;
        case (state_q)
            DMEM_IDLE: begin
                if (accept && ACCESS_LATENCY > 1) begin
                    req_d   = core2dmem_req_Q103H;
                    cnt_d   = CNT_LOAD;
                    state_d = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                dmem_ready_Q103H = 1'b0;
                if (cnt_q == '0) begin
                    state_d = DMEM_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Latency 1 bypasses the holding register so back-to-back requests stream.
    assign acc_fire = (ACCESS_LATENCY == 1) ? accept
                                            : (state_q == DMEM_BUSY) && (cnt_q == '0);
    assign acc_req  = (ACCESS_LATENCY == 1) ? core2dmem_req_Q103H : req_q;

    assign acc_oor = (acc_req.address >> (AW + 2)) != 32'd0;
    // rd+wr together is executed as a write only.
    assign acc_rd  = acc_req.rd_en & ~acc_req.wr_en;
    assign arr_we  = acc_fire & acc_req.wr_en & ~acc_oor;
    assign arr_re  = acc_fire & acc_rd & ~acc_oor;

    rv_dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (arr_we),
        .re      (arr_re),
        .addr    (acc_req.address[AW+1:2]),
        .wr_data (acc_req.wr_data),
        .byte_en (acc_req.byte_en),
        .rd_data (arr_rd_data)
    );

    // zero_q masks the array register after an out-of-range load; both only
    // change on a load, so rsp_rd_data holds between loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            rd_valid_q <= acc_fire & acc_rd;
            err_q      <= acc_fire & (acc_oor | (acc_req.rd_en & acc_req.wr_en));
            if (acc_fire && acc_rd) begin
                zero_q <= acc_oor;
            end
        end
    end

    assign rsp = '{rd_data: (zero_q ? 32'd0 : arr_rd_data), rd_valid: rd_valid_q, err: err_q};

    assign rsp_rd_data  = rsp.rd_data;
    assign rsp_rd_valid = rsp.rd_valid;
    assign rsp_err      = rsp.err;

endmodule
